ssd_mux_driver: RTL and testbench
=================================

SSD_MUX_DRIVER -- requirements
Module: ssd_mux_driver

Interface
REQ-001 The block SHALL have parameter NDIG, default 4: number of multiplexed digits, range 2..8.
REQ-002 The block SHALL have parameter W, default 16: data_in width, range 4..32.
REQ-003 The block SHALL have parameter SCAN_DIV, default 100_000: clk cycles per digit slot, minimum 2.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port nrst, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port data_in, input, W bits: value to display.
REQ-007 The block SHALL have port mode, input, 2 bits: 00 hex, 01 unsigned decimal, 10 signed decimal (two's complement), 11 reserved (treated as hex).
REQ-008 The block SHALL have port load, input, 1 bit: one-cycle strobe that samples data_in and mode.
REQ-009 The block SHALL have port busy, output, 1 bit: conversion in progress.
REQ-010 The block SHALL have port ovf, output, 1 bit: the last converted value did not fit in NDIG digits.
REQ-011 The block SHALL have port seg, output, 7 bits: {A,B,C,D,E,F,G}, 1 = lit.
REQ-012 The block SHALL have port an, output, NDIG bits: one-hot digit enable, active-high; bit 0 is the rightmost digit.

Function
REQ-013 load with busy=0 SHALL latch data_in and mode; load with busy=1 SHALL be ignored (no queueing).
REQ-014 busy SHALL rise the cycle after an accepted load; hex conversion SHALL keep busy high for exactly 1 cycle; decimal conversion SHALL keep it high for exactly W+1 cycles (W double-dabble shifts plus 1 format cycle).
REQ-015 The display buffer and ovf SHALL update on the same edge at which busy falls; the buffer SHALL never show a partial conversion.
REQ-016 Hex mode SHALL place nibble k in digit k, with no blanking; ovf=1 when W>4*NDIG and any bit above 4*NDIG-1 is set.
REQ-017 Unsigned decimal mode SHALL suppress leading zeros; value 0 SHALL show a single '0' in digit 0; ovf=1 when value >= 10^NDIG.
REQ-018 Signed decimal mode SHALL convert the magnitude; a negative result SHALL place '-' in the digit immediately left of the most significant nonzero digit; ovf=1 when the magnitude needs more than NDIG-1 digits. The most negative value SHALL be converted correctly, with a W+1-bit magnitude.
REQ-019 On ovf=1, every digit SHALL show '-' (seg=0000001).
REQ-020 Glyphs SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111, '-'=0000001, blank=0000000.
REQ-021 The scan counter SHALL count 0..SCAN_DIV-1; on wrap, the digit index SHALL advance, wrapping NDIG-1 to 0.
REQ-022 an SHALL be the one-hot of the digit index; seg SHALL be the glyph of the buffer entry for that index, registered so that seg and an change on the same edge.
REQ-023 Scanning SHALL continue unaffected by load or busy.

Reset
REQ-024 nrst=0 SHALL force: busy=0, ovf=0, all buffer entries blank, scan counter 0, digit index 0, an=0...01, seg=0000000.
REQ-025 nrst=0 SHALL take priority over a load in the same cycle and SHALL abort any conversion in progress; no buffer update SHALL follow.

Structure
REQ-026 Package ssd_pkg SHALL hold the mode encodings, the 5-bit glyph codes (0-F, MINUS=5'h10, BLANK=5'h1F) and the glyph-to-segment function.
REQ-027 Iterative binary-to-BCD conversion SHALL be a sub-module, bin2bcd_seq (start/done, W-bit in, NDIG+1 BCD digits out); formatting and scanning SHALL stay in ssd_mux_driver.

Verification (NDIG=4, W=16, SCAN_DIV=4)
REQ-028 Hex: load 16'hBEEF, mode 00 -> busy high 1 cycle; digits 3..0 = b,E,E,F; ovf=0; an cycles 0001->0010->0100->1000 every 4 clk.
REQ-029 Unsigned: load 1234, mode 01 -> busy high 17 cycles, then digits 1,2,3,4; load 7 -> blank,blank,blank,7; load 12345 -> ovf=1, all '-'.
REQ-030 Signed: load 16'hFFF9 (-7), mode 10 -> blank,blank,'-',7; -999 -> '-',9,9,9; -1000 -> ovf=1; 16'h8000 -> ovf=1 with no lockup.
REQ-031 Load while busy: second load 5 issued 3 cycles into the conversion of 42 -> display shows 42 and the second load is dropped.
REQ-032 Reset mid-conversion: nrst=0 for 1 cycle at busy cycle 8 -> busy=0, display blank, an=0001, no later update.

Source files
------------

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared definitions for the multiplexed seven-segment driver.
//   - display mode encodings carried on the mode port
//   - 5-bit glyph codes held in the display buffer (0..F, MINUS, BLANK)
//   - conversion controller state type
//   - glyph_to_seg: glyph code -> {A,B,C,D,E,F,G} segment pattern, 1 = lit
package ssd_pkg;

    localparam logic [1:0] MODE_HEX  = 2'b00;
    localparam logic [1:0] MODE_UDEC = 2'b01;
    localparam logic [1:0] MODE_SDEC = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;   // displayed as hex

    localparam logic [4:0] GLYPH_MINUS = 5'h10;
    localparam logic [4:0] GLYPH_BLANK = 5'h1F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEX,
        ST_DEC
    } conv_state_t;

    function automatic logic [6:0] glyph_to_seg(input logic [4:0] g);
        logic [6:0] s;
        case (g)
            5'h00:   s = 7'b1111110;
            5'h01:   s = 7'b0110000;
            5'h02:   s = 7'b1101101;
            5'h03:   s = 7'b1111001;
            5'h04:   s = 7'b0110011;
            5'h05:   s = 7'b1011011;
            5'h06:   s = 7'b1011111;
            5'h07:   s = 7'b1110000;
            5'h08:   s = 7'b1111111;
            5'h09:   s = 7'b1111011;
            5'h0A:   s = 7'b1110111;
            5'h0B:   s = 7'b0011111;
            5'h0C:   s = 7'b1001110;
            5'h0D:   s = 7'b0111101;
            5'h0E:   s = 7'b1001111;
            5'h0F:   s = 7'b1000111;
            5'h10:   s = 7'b0000001;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative (double-dabble) binary to BCD converter.
//   clk, nrst : clock, synchronous active-low reset (aborts a conversion)
//   start     : one-cycle strobe; samples bin
//   bin       : W-bit unsigned value
//   done      : one-cycle pulse, W cycles after start, when bcd is final
//   bcd       : NDIG+1 BCD digits, digit 0 in bits [3:0]
// Digits beyond NDIG+1 are discarded; the lower digits are still exact
// (value mod 10^(NDIG+1)) because each adjust only looks at its own digit.
module bin2bcd_seq
    import ssd_pkg::*;
#(
    parameter int W    = 16,
    parameter int NDIG = 4
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    start,
    input  logic [W-1:0]            bin,
    output logic                    done,
    output logic [4*(NDIG+1)-1:0]   bcd
);

    localparam int BW = 4 * (NDIG + 1);
    localparam int CW = $clog2(W + 1);

    logic          active_q;
    logic          done_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  sh_q;
    logic [BW-1:0] bcd_q;

    function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = b;
        for (int d = 0; d < NDIG + 1; d++) begin
            if (b[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = b[4*d +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!nrst) begin
            active_q <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                active_q <= 1'b1;
                cnt_q    <= CW'(W);
            end else if (active_q) begin
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    active_q <= 1'b0;
                    done_q   <= 1'b1;
                end
            end
        end
    end

    // Shift datapath: one adjust-and-shift per cycle while active.
    always_ff @(posedge clk) begin
        if (start) begin
            sh_q  <= bin;
            bcd_q <= '0;
        end else if (active_q) begin
            {bcd_q, sh_q} <= {add3(bcd_q), sh_q} << 1;
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/ssd_mux_driver.sv
// ssd_mux_driver: converts a loaded value to hex / unsigned / signed decimal
// glyphs and scans them onto a multiplexed seven-segment display.
//   clk, nrst : clock, synchronous active-low reset
//   data_in   : W-bit value, sampled with mode on an accepted load
//   mode      : 00 hex, 01 unsigned dec, 10 signed dec, 11 hex
//   load      : one-cycle strobe, ignored while busy
//   busy      : conversion in progress
//   ovf       : last converted value did not fit (display shows all '-')
//   seg       : {A,B,C,D,E,F,G} of the digit selected by an, 1 = lit
//   an        : one-hot active-high digit enable, bit 0 = rightmost digit
module ssd_mux_driver
    import ssd_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int W        = 16,
    parameter int SCAN_DIV = 100_000
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [W-1:0]    data_in,
    input  logic [1:0]      mode,
    input  logic            load,
    output logic            busy,
    output logic            ovf,
    output logic [6:0]      seg,
    output logic [NDIG-1:0] an
);

    localparam int BD   = NDIG + 1;
    localparam int IW   = $clog2(NDIG);
    localparam int CNTW = $clog2(SCAN_DIV);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] LIM_U = pow10(NDIG);
    localparam logic [63:0] LIM_S = pow10(NDIG - 1);

    conv_state_t         state_q;
    logic                busy_q;
    logic                ovf_q;
    logic                ovf_pend_q;
    logic                neg_q;
    logic [4*NDIG-1:0]   nib_q;
    logic [4:0]          disp_q [NDIG];

    logic [CNTW-1:0]     cnt_q;
    logic [IW-1:0]       idx_q;
    logic [NDIG-1:0]     an_q;
    logic [6:0]          seg_q;

    logic                accept;
    logic                is_hex_in;
    logic                neg_in;
    logic signed [W:0]   sval;
    logic [W:0]          mag;
    logic                hex_ovf_in;
    logic                dec_ovf_in;
    logic [4*NDIG-1:0]   nib_in;

    logic                bcd_done;
    logic [4*BD-1:0]     bcd;
    logic                dec_ovf;
    logic [4:0]          hex_glyph [NDIG];
    logic [4:0]          dec_glyph [NDIG];

    assign accept = load && (state_q == ST_IDLE);

    // Input side: classify the value and decide overflow at load time.
    // The magnitude is W+1 bits so the most negative value negates cleanly.
    // Positive values in signed mode need no sign position, so they get the
    // full NDIG-digit range.
    always_comb begin
        is_hex_in  = (mode == MODE_HEX) || (mode == MODE_RSVD);
        neg_in     = (mode == MODE_SDEC) && data_in[W-1];
        sval       = neg_in ? signed'({1'b1, data_in}) : signed'({1'b0, data_in});
        mag        = neg_in ? unsigned'(-sval) : unsigned'(sval);
        nib_in     = (4*NDIG)'(data_in);
        hex_ovf_in = (W > 4*NDIG) && ((data_in >> (4*NDIG)) != '0);
        dec_ovf_in = 64'(mag) >= (neg_in ? LIM_S : LIM_U);
    end

    bin2bcd_seq #(
        .W    (W),
        .NDIG (NDIG)
    ) u_bin2bcd (
        .clk   (clk),
        .nrst  (nrst),
        .start (accept && !is_hex_in),
        .bin   (mag[W-1:0]),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    // Formatting: hex shows every nibble; decimal blanks leading zeros and
    // puts '-' just left of the most significant nonzero digit. A nonzero
    // top BCD digit is a second witness of overflow for the decimal path.
    always_comb begin
        int msd;
        dec_ovf = ovf_pend_q || (bcd[4*NDIG +: 4] != 4'd0);
        msd     = 0;
        for (int k = 0; k < NDIG; k++) begin
            if (bcd[4*k +: 4] != 4'd0) begin
                msd = k;
            end
        end
        for (int k = 0; k < NDIG; k++) begin
            hex_glyph[k] = ovf_pend_q ? GLYPH_MINUS : {1'b0, nib_q[4*k +: 4]};
            if (dec_ovf) begin
                dec_glyph[k] = GLYPH_MINUS;
            end else if (k <= msd) begin
                dec_glyph[k] = {1'b0, bcd[4*k +: 4]};
            end else if (neg_q && (k == msd + 1)) begin
                dec_glyph[k] = GLYPH_MINUS;
            end else begin
                dec_glyph[k] = GLYPH_BLANK;
            end
        end
    end

    // Conversion controller: the buffer and ovf change only on the edge
    // where busy falls, so a partial result is never visible.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
            for (int k = 0; k < NDIG; k++) begin
                disp_q[k] <= GLYPH_BLANK;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        busy_q     <= 1'b1;
                        ovf_pend_q <= is_hex_in ? hex_ovf_in : dec_ovf_in;
                        state_q    <= is_hex_in ? ST_HEX : ST_DEC;
                    end
                end
                ST_HEX: begin
                    for (int k = 0; k < NDIG; k++) begin
                        disp_q[k] <= hex_glyph[k];
                    end
                    ovf_q   <= ovf_pend_q;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_DEC: begin
                    if (bcd_done) begin
                        for (int k = 0; k < NDIG; k++) begin
                            disp_q[k] <= dec_glyph[k];
                        end
                        ovf_q   <= dec_ovf;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Latched operand for the hex path.
    always_ff @(posedge clk) begin
        if (accept) begin
            nib_q <= nib_in;
            neg_q <= neg_in;
        end
    end

    // Scan: an and seg are registered together from the current index.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_q <= '0;
            idx_q <= '0;
            an_q  <= NDIG'(1);
            seg_q <= 7'b0000000;
        end else begin
            if (cnt_q == CNTW'(SCAN_DIV - 1)) begin
                cnt_q <= '0;
                idx_q <= (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            an_q  <= NDIG'(1) << idx_q;
            seg_q <= glyph_to_seg(disp_q[idx_q]);
        end
    end

    assign busy = busy_q;
    assign ovf  = ovf_q;
    assign an   = an_q;
    assign seg  = seg_q;

endmodule

// File: tb/tb_ssd_mux_driver.sv
module tb_ssd_mux_driver;

    localparam int NDIG = 4;
    localparam int W    = 16;
    localparam int SDIV = 4;

    localparam logic [6:0] G0 = 7'b1111110, G1 = 7'b0110000, G2 = 7'b1101101;
    localparam logic [6:0] G3 = 7'b1111001, G4 = 7'b0110011, G5 = 7'b1011011;
    localparam logic [6:0] G7 = 7'b1110000, G9 = 7'b1111011;
    localparam logic [6:0] GA = 7'b1110111, GB = 7'b0011111, GE = 7'b1001111;
    localparam logic [6:0] GF = 7'b1000111, GM = 7'b0000001, GZ = 7'b0000000;

    logic            clk = 1'b0;
    logic            nrst;
    logic [W-1:0]    data_in;
    logic [1:0]      mode;
    logic            load;
    logic            busy;
    logic            ovf;
    logic [6:0]      seg;
    logic [NDIG-1:0] an;

    int n_checks = 0;
    int n_err    = 0;
    logic [6:0] disp [NDIG];

    typedef struct {
        logic [15:0] d;
        logic [1:0]  m;
        int          cyc;
        logic        ovf;
        logic [6:0]  g3, g2, g1, g0;
    } vec_t;

    vec_t tbl [16];

    ssd_mux_driver #(.NDIG(NDIG), .W(W), .SCAN_DIV(SDIV)) dut (
        .clk     (clk),
        .nrst    (nrst),
        .data_in (data_in),
        .mode    (mode),
        .load    (load),
        .busy    (busy),
        .ovf     (ovf),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Collect the glyph shown for every digit over one scan.
    task automatic read_display();
        logic [NDIG-1:0] want;
        int n;
        @(negedge clk);
        for (int k = 0; k < NDIG; k++) begin
            want = NDIG'(1 << k);
            n = 0;
            while (an !== want && n < 64) begin
                @(negedge clk);
                n++;
            end
            if (n >= 64) check($sformatf("scan_timeout_d%0d", k), 32'(an), 32'(want));
            disp[k] = seg;
        end
    endtask

    // Issue one load and count the cycles busy stays high.
    task automatic do_load(input logic [15:0] d, input logic [1:0] m, output int ncyc);
        @(negedge clk);
        data_in = d;
        mode    = m;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        ncyc = 0;
        while (busy && ncyc < 100) begin
            ncyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int ncyc;
        int nchg;
        int last_chg;
        logic [NDIG-1:0] prev_an;
        logic bad;

        tbl[0]  = '{16'hBEEF, 2'b00,  1, 1'b0, GB, GE, GE, GF};
        tbl[1]  = '{16'd1234, 2'b01, 17, 1'b0, G1, G2, G3, G4};
        tbl[2]  = '{16'd7,    2'b01, 17, 1'b0, GZ, GZ, GZ, G7};
        tbl[3]  = '{16'd12345,2'b01, 17, 1'b1, GM, GM, GM, GM};
        tbl[4]  = '{16'hFFF9, 2'b10, 17, 1'b0, GZ, GZ, GM, G7};
        tbl[5]  = '{16'hFC19, 2'b10, 17, 1'b0, GM, G9, G9, G9};
        tbl[6]  = '{16'hFC18, 2'b10, 17, 1'b1, GM, GM, GM, GM};
        tbl[7]  = '{16'h8000, 2'b10, 17, 1'b1, GM, GM, GM, GM};
        tbl[8]  = '{16'd0,    2'b01, 17, 1'b0, GZ, GZ, GZ, G0};
        tbl[9]  = '{16'h1234, 2'b11,  1, 1'b0, G1, G2, G3, G4};
        tbl[10] = '{16'd9999, 2'b01, 17, 1'b0, G9, G9, G9, G9};
        tbl[11] = '{16'd10000,2'b01, 17, 1'b1, GM, GM, GM, GM};
        tbl[12] = '{16'hFFFF, 2'b01, 17, 1'b1, GM, GM, GM, GM};
        tbl[13] = '{16'h00A0, 2'b00,  1, 1'b0, G0, G0, GA, G0};
        tbl[14] = '{16'd5,    2'b10, 17, 1'b0, GZ, GZ, GZ, G5};
        tbl[15] = '{16'hFFFF, 2'b10, 17, 1'b0, GZ, GZ, GM, G1};

        nrst = 1'b0; load = 1'b0; data_in = '0; mode = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);
        check("rst_an",   32'(an),   32'd1);
        check("rst_seg",  32'(seg),  32'd0);

        // Scan rotation: each change is a left rotate, 4 clocks apart.
        nrst = 1'b1;
        prev_an = an; nchg = 0; last_chg = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (an !== prev_an) begin
                check($sformatf("rot_val%0d", nchg), 32'(an),
                      32'({prev_an[NDIG-2:0], prev_an[NDIG-1]}));
                if (nchg > 0) check($sformatf("rot_period%0d", nchg), 32'(i - last_chg), 32'd4);
                nchg++;
                last_chg = i;
                prev_an = an;
            end
        end
        check("rot_changes", 32'(nchg >= 4), 32'd1);

        for (int v = 0; v < 16; v++) begin
            do_load(tbl[v].d, tbl[v].m, ncyc);
            check($sformatf("v%0d_busy_cycles", v), 32'(ncyc), 32'(tbl[v].cyc));
            check($sformatf("v%0d_ovf", v), 32'(ovf), 32'(tbl[v].ovf));
            read_display();
            check($sformatf("v%0d_d3", v), 32'(disp[3]), 32'(tbl[v].g3));
            check($sformatf("v%0d_d2", v), 32'(disp[2]), 32'(tbl[v].g2));
            check($sformatf("v%0d_d1", v), 32'(disp[1]), 32'(tbl[v].g1));
            check($sformatf("v%0d_d0", v), 32'(disp[0]), 32'(tbl[v].g0));
        end

        // Load while busy: second load 3 cycles into converting 42 is dropped.
        @(negedge clk);
        data_in = 16'd42; mode = 2'b01; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("lwb_busy_rise", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        data_in = 16'd5; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        ncyc = 0;
        while (busy && ncyc < 100) begin
            ncyc++;
            @(negedge clk);
        end
        check("lwb_busy_rest", 32'(ncyc), 32'd14);
        bad = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (busy) bad = 1'b1;
            @(negedge clk);
        end
        check("lwb_no_requeue", 32'(bad), 32'd0);
        read_display();
        check("lwb_d3", 32'(disp[3]), 32'(GZ));
        check("lwb_d2", 32'(disp[2]), 32'(GZ));
        check("lwb_d1", 32'(disp[1]), 32'(G4));
        check("lwb_d0", 32'(disp[0]), 32'(G2));
        check("lwb_ovf", 32'(ovf), 32'd0);

        // Reset at busy cycle 8 of a decimal conversion.
        @(negedge clk);
        data_in = 16'd1234; mode = 2'b01; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (7) @(negedge clk);
        check("rmid_busy_before", 32'(busy), 32'd1);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        check("rmid_busy", 32'(busy), 32'd0);
        check("rmid_an",   32'(an),   32'd1);
        check("rmid_seg",  32'(seg),  32'd0);
        check("rmid_ovf",  32'(ovf),  32'd0);
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy || seg != 7'b0000000 || ovf) bad = 1'b1;
        end
        check("rmid_no_update", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
